state_dump_unit: RTL and testbench
==================================

STATE_DUMP_UNIT -- requirements
Module: state_dump_unit

Interface
REQ-001 Parameter REG_WIDTH, default 64: register-file and data-memory word width.
REQ-002 Parameter RF_DEPTH, default 32: number of register-file entries dumped; RF_AW = clog2(RF_DEPTH).
REQ-003 Parameter DMEM_DUMP_DEPTH, default 9: number of data-memory words dumped (0 legal).
REQ-004 Parameter DMEM_ADDR_WIDTH, default 10: data-memory word-address width.
REQ-005 Parameter CNT_WIDTH, default 16: cycle-counter width.
REQ-006 clk  in  1  single clock; all state updates on rising edge.
REQ-007 reset_b  in  1  asynchronous, active-low reset.
REQ-008 run_cycles  in  CNT_WIDTH  rising edges after reset release before auto-trigger; 0 disables auto-trigger.
REQ-009 halt_i  in  1  external dump trigger, sampled on rising edges.
REQ-010 rf_raddr  out  RF_AW  register-file read address.
REQ-011 rf_rdata  in  REG_WIDTH  combinational register-file read data.
REQ-012 dm_raddr  out  DMEM_ADDR_WIDTH  data-memory word read address.
REQ-013 dm_rdata  in  REG_WIDTH  combinational data-memory read data.
REQ-014 cpu_stall  out  1  freezes the CPU (no PC, RF or DMEM update) while high.
REQ-015 dump_valid  out  1  dump beat valid.
REQ-016 dump_ready  in  1  consumer accepts beat.
REQ-017 dump_is_mem  out  1  0 = RF beat, 1 = DMEM beat.
REQ-018 dump_index  out  16  entry index of current beat.
REQ-019 dump_data  out  REG_WIDTH  entry contents.
REQ-020 dump_last  out  1  marks final beat.
REQ-021 done  out  1  dump complete.
REQ-022 cycle_count  out  CNT_WIDTH  rising edges counted in RUN.

Function
REQ-023 FSM states: RUN, DUMP_RF, DUMP_MEM, DONE.
REQ-024 In RUN, cycle_count increments by 1 every rising edge, saturating at all-ones.
REQ-025 Trigger at an edge in RUN: halt_i=1, or (run_cycles!=0 and cycle_count==run_cycles-1); simultaneous causes give one trigger.
REQ-026 On the trigger edge cycle_count still increments, then freezes; state moves to DUMP_RF.
REQ-027 cpu_stall = (state != RUN), combinational from state.
REQ-028 dump_valid = 1 in DUMP_RF and DUMP_MEM, else 0.
REQ-029 Beat index held in a counter starting at 0; rf_raddr/dm_raddr = index; dump_data = rf_rdata in DUMP_RF, dm_rdata in DUMP_MEM.
REQ-030 Handshake: beat transfers on an edge with dump_valid and dump_ready both 1; index, state and data hold stable while dump_valid=1 and dump_ready=0.
REQ-031 DUMP_RF: on transfer of index RF_DEPTH-1, index resets to 0 and state moves to DUMP_MEM, or to DONE if DMEM_DUMP_DEPTH=0; otherwise index+1.
REQ-032 DUMP_MEM: on transfer of index DMEM_DUMP_DEPTH-1, state moves to DONE; otherwise index+1.
REQ-033 dump_last = 1 on the final beat only: DMEM index DMEM_DUMP_DEPTH-1, or RF index RF_DEPTH-1 when DMEM_DUMP_DEPTH=0.
REQ-034 DONE is terminal until reset: done=1, cpu_stall=1, dump_valid=0; halt_i ignored.
REQ-035 halt_i and run_cycles are ignored outside RUN; changing run_cycles in RUN takes effect at the next comparison.

Reset
REQ-036 reset_b=0 immediately forces state=RUN, cycle_count=0, index=0, dump_valid=0, dump_last=0, done=0, cpu_stall=0, rf_raddr=0, dm_raddr=0, dump_is_mem=0.
REQ-037 Reset asserted mid-dump abandons the dump; after release, counting restarts from 0 with no residual beats.

Verification
REQ-038 run_cycles=45, halt_i=0, dump_ready=1 -> cpu_stall rises after 45th edge; 41 beats: RF 0..31 then DMEM 0..8; dump_last on DMEM[8]; done=1; cycle_count=45.
REQ-039 Random dump_ready backpressure -> dump_data/dump_index stable while stalled; exactly 41 beats, none duplicated or skipped.
REQ-040 run_cycles=45, halt_i pulsed at edge 10 -> dump starts after edge 10; cycle_count=10.
REQ-041 run_cycles=0, halt_i=0 for 1000 cycles -> cpu_stall=0, dump_valid=0, cycle_count=1000.
REQ-042 reset_b driven low during beat 20 -> all outputs reset values same cycle; after release, auto-trigger after 45 more edges.
REQ-043 DMEM_DUMP_DEPTH=0 -> 32 RF beats only, dump_last on RF[31], then done=1.

Source files
------------

// File: rtl/state_dump_unit.sv
// Post-run architectural state dump: counts RUN cycles, then on halt or cycle budget freezes the
// CPU and streams the register file followed by a data-memory window over a valid/ready port.
module state_dump_unit #(
    parameter int unsigned REG_WIDTH       = 64,
    parameter int unsigned RF_DEPTH        = 32,
    parameter int unsigned DMEM_DUMP_DEPTH = 9,
    parameter int unsigned DMEM_ADDR_WIDTH = 10,
    parameter int unsigned CNT_WIDTH       = 16,
    localparam int unsigned RF_AW          = (RF_DEPTH > 1) ? $clog2(RF_DEPTH) : 1
) (
    input  logic                       clk,
    input  logic                       reset_b,
    input  logic [CNT_WIDTH-1:0]       run_cycles,
    input  logic                       halt_i,
    output logic [RF_AW-1:0]           rf_raddr,
    input  logic [REG_WIDTH-1:0]       rf_rdata,
    output logic [DMEM_ADDR_WIDTH-1:0] dm_raddr,
    input  logic [REG_WIDTH-1:0]       dm_rdata,
    output logic                       cpu_stall,
    output logic                       dump_valid,
    input  logic                       dump_ready,
    output logic                       dump_is_mem,
    output logic [15:0]                dump_index,
    output logic [REG_WIDTH-1:0]       dump_data,
    output logic                       dump_last,
    output logic                       done,
    output logic [CNT_WIDTH-1:0]       cycle_count
);

    typedef enum logic [1:0] {
        StRun,
        StDumpRf,
        StDumpMem,
        StDone
    } state_e;

    localparam bit          HasMem  = (DMEM_DUMP_DEPTH != 0);
    localparam logic [15:0] RfLast  = 16'(RF_DEPTH - 1);
    localparam logic [15:0] MemLast = HasMem ? 16'(DMEM_DUMP_DEPTH - 1) : 16'd0;

    state_e               state_q;
    logic [CNT_WIDTH-1:0] cnt_q;
    logic [15:0]          idx_q;

    logic [CNT_WIDTH-1:0] run_target;
    logic                 trigger;
    logic                 xfer;
    logic                 rf_last_beat;
    logic                 mem_last_beat;

    always_comb begin
        run_target    = run_cycles - CNT_WIDTH'(1);
        // Budget check uses the pre-increment count, so the trigger lands on edge run_cycles.
        trigger       = halt_i || ((run_cycles != '0) && (cnt_q == run_target));
        xfer          = dump_valid && dump_ready;
        rf_last_beat  = (idx_q == RfLast);
        mem_last_beat = (idx_q == MemLast);
    end

    always_ff @(posedge clk or negedge reset_b) begin
        if (!reset_b) begin
            state_q <= StRun;
            cnt_q   <= '0;
            idx_q   <= '0;
        end else begin
            case (state_q)
                StRun: begin
                    if (cnt_q != '1) begin
                        cnt_q <= cnt_q + CNT_WIDTH'(1);
                    end
                    idx_q <= '0;
                    if (trigger) begin
                        state_q <= StDumpRf;
                    end
                end
                StDumpRf: begin
                    if (xfer) begin
                        if (rf_last_beat) begin
                            idx_q <= '0;
                            if (HasMem) begin
                                state_q <= StDumpMem;
                            end else begin
                                state_q <= StDone;
                            end
                        end else begin
                            idx_q <= idx_q + 16'd1;
                        end
                    end
                end
                StDumpMem: begin
                    if (xfer) begin
                        if (mem_last_beat) begin
                            state_q <= StDone;
                        end else begin
                            idx_q <= idx_q + 16'd1;
                        end
                    end
                end
                StDone: begin
                    state_q <= StDone;
                end
                default: begin
                    state_q <= StRun;
                end
            endcase
        end
    end

    always_comb begin
        cpu_stall   = (state_q != StRun);
        dump_valid  = (state_q == StDumpRf) || (state_q == StDumpMem);
        dump_is_mem = (state_q == StDumpMem);
        done        = (state_q == StDone);
        dump_index  = idx_q;
        cycle_count = cnt_q;
        rf_raddr    = idx_q[RF_AW-1:0];
        dm_raddr    = idx_q[DMEM_ADDR_WIDTH-1:0];
        dump_data   = dump_is_mem ? dm_rdata : rf_rdata;
        dump_last   = ((state_q == StDumpMem) && mem_last_beat) ||
                      (!HasMem && (state_q == StDumpRf) && rf_last_beat);
    end

endmodule

// File: tb/tb_state_dump_unit.sv
// Directed bench for state_dump_unit: a default instance plus a DMEM_DUMP_DEPTH=0 instance,
// beats checked against a scoreboard of expected dump contents.
module tb_state_dump_unit;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    // Instance A: default parameters
    logic        reset_b, halt_i, dump_ready;
    logic [15:0] run_cycles;
    logic [4:0]  rf_raddr;
    logic [9:0]  dm_raddr;
    logic [63:0] rf_rdata, dm_rdata, dump_data;
    logic        cpu_stall, dump_valid, dump_is_mem, dump_last, done;
    logic [15:0] dump_index, cycle_count;

    // Instance B: no data-memory window
    logic        reset_b_b, halt_b, ready_b;
    logic [15:0] run_cycles_b;
    logic [4:0]  rf_raddr_b;
    logic [9:0]  dm_raddr_b;
    logic [63:0] rf_rdata_b, dm_rdata_b, dump_data_b;
    logic        cpu_stall_b, dump_valid_b, dump_is_mem_b, dump_last_b, done_b;
    logic [15:0] dump_index_b, cycle_count_b;

    function automatic logic [63:0] rf_val(input logic [15:0] i);
        return 64'hF00D_0000_0000_0000 | (64'(i) * 64'd7 + 64'd1);
    endfunction

    function automatic logic [63:0] dm_val(input logic [15:0] i);
        return 64'hBEEF_0000_0000_0000 | (64'(i) * 64'd13 + 64'd5);
    endfunction

    assign rf_rdata   = rf_val(16'(rf_raddr));
    assign dm_rdata   = dm_val(16'(dm_raddr));
    assign rf_rdata_b = rf_val(16'(rf_raddr_b));
    assign dm_rdata_b = dm_val(16'(dm_raddr_b));

    state_dump_unit u_dut (
        .clk        (clk),
        .reset_b    (reset_b),
        .run_cycles (run_cycles),
        .halt_i     (halt_i),
        .rf_raddr   (rf_raddr),
        .rf_rdata   (rf_rdata),
        .dm_raddr   (dm_raddr),
        .dm_rdata   (dm_rdata),
        .cpu_stall  (cpu_stall),
        .dump_valid (dump_valid),
        .dump_ready (dump_ready),
        .dump_is_mem(dump_is_mem),
        .dump_index (dump_index),
        .dump_data  (dump_data),
        .dump_last  (dump_last),
        .done       (done),
        .cycle_count(cycle_count)
    );

    state_dump_unit #(.DMEM_DUMP_DEPTH(0)) u_dut_nomem (
        .clk        (clk),
        .reset_b    (reset_b_b),
        .run_cycles (run_cycles_b),
        .halt_i     (halt_b),
        .rf_raddr   (rf_raddr_b),
        .rf_rdata   (rf_rdata_b),
        .dm_raddr   (dm_raddr_b),
        .dm_rdata   (dm_rdata_b),
        .cpu_stall  (cpu_stall_b),
        .dump_valid (dump_valid_b),
        .dump_ready (ready_b),
        .dump_is_mem(dump_is_mem_b),
        .dump_index (dump_index_b),
        .dump_data  (dump_data_b),
        .dump_last  (dump_last_b),
        .done       (done_b),
        .cycle_count(cycle_count_b)
    );

    typedef struct packed {
        logic        is_mem;
        logic [15:0] idx;
        logic [63:0] data;
        logic        last;
    } beat_t;

    beat_t qa[$];
    beat_t qb[$];
    int    checks  = 0;
    int    errors  = 0;
    int    beats_a = 0;
    int    beats_b = 0;
    bit    hold_a  = 1'b0;
    beat_t held_a;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic push_dump(input bit to_b, input int mem_depth);
        beat_t b;
        for (int i = 0; i < 32; i++) begin
            b = '{is_mem: 1'b0, idx: 16'(i), data: rf_val(16'(i)),
                  last: (mem_depth == 0) && (i == 31)};
            if (to_b) qb.push_back(b);
            else      qa.push_back(b);
        end
        for (int i = 0; i < mem_depth; i++) begin
            b = '{is_mem: 1'b1, idx: 16'(i), data: dm_val(16'(i)), last: (i == mem_depth - 1)};
            if (to_b) qb.push_back(b);
            else      qa.push_back(b);
        end
    endtask

    // Sampled on the falling edge: a beat seen valid&ready here transfers on the next rising edge.
    task automatic mon_a();
        beat_t e;
        if (hold_a) begin
            chk("hold_valid", dump_valid, 1);
            chk("hold_is_mem", dump_is_mem, held_a.is_mem);
            chk("hold_index", dump_index, held_a.idx);
            chk("hold_data", dump_data, held_a.data);
        end
        hold_a = reset_b && dump_valid && !dump_ready;
        held_a = '{is_mem: dump_is_mem, idx: dump_index, data: dump_data, last: dump_last};
        if (reset_b && dump_valid && dump_ready) begin
            chk("sb_a_nonempty", qa.size() > 0, 1);
            if (qa.size() > 0) begin
                e = qa.pop_front();
                chk("beat_is_mem", dump_is_mem, e.is_mem);
                chk("beat_index", dump_index, e.idx);
                chk("beat_data", dump_data, e.data);
                chk("beat_last", dump_last, e.last);
                beats_a++;
            end
        end
    endtask

    task automatic mon_b();
        beat_t e;
        if (reset_b_b && dump_valid_b && ready_b) begin
            chk("sb_b_nonempty", qb.size() > 0, 1);
            if (qb.size() > 0) begin
                e = qb.pop_front();
                chk("b_beat_is_mem", dump_is_mem_b, e.is_mem);
                chk("b_beat_index", dump_index_b, e.idx);
                chk("b_beat_data", dump_data_b, e.data);
                chk("b_beat_last", dump_last_b, e.last);
                beats_b++;
            end
        end
    endtask

    always @(negedge clk) begin
        mon_a();
        mon_b();
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic restart_a(input logic [15:0] rc);
        reset_b    = 1'b0;
        halt_i     = 1'b0;
        dump_ready = 1'b1;
        run_cycles = rc;
        tick();
        qa.delete();
        beats_a = 0;
        reset_b = 1'b1;
    endtask

    task automatic wait_done_a(input int bound, input bit rnd);
        for (int i = 0; i < bound && !done; i++) begin
            if (rnd) dump_ready = 1'($urandom_range(0, 1));
            tick();
        end
        dump_ready = 1'b1;
        chk("done_reached", done, 1);
        chk("sb_a_drained", qa.size(), 0);
        chk("beats_a_total", beats_a, 41);
        chk("done_valid_low", dump_valid, 0);
        chk("done_stall_high", cpu_stall, 1);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish, checks=%0d", checks);
        $fatal(1, "watchdog expired");
    end

    initial begin
        reset_b      = 1'b0;
        halt_i       = 1'b0;
        dump_ready   = 1'b1;
        run_cycles   = 16'd45;
        reset_b_b    = 1'b0;
        halt_b       = 1'b0;
        ready_b      = 1'b1;
        run_cycles_b = 16'd45;
        #1;
        chk("rst_stall", cpu_stall, 0);
        chk("rst_valid", dump_valid, 0);
        chk("rst_done", done, 0);
        chk("rst_last", dump_last, 0);
        chk("rst_is_mem", dump_is_mem, 0);
        chk("rst_count", cycle_count, 0);
        chk("rst_index", dump_index, 0);
        chk("rst_rf_raddr", rf_raddr, 0);
        chk("rst_dm_raddr", dm_raddr, 0);

        // Auto-trigger after 45 edges, full-rate consumer
        restart_a(16'd45);
        push_dump(1'b0, 9);
        repeat (44) tick();
        chk("auto_pre_stall", cpu_stall, 0);
        chk("auto_pre_count", cycle_count, 44);
        tick();
        chk("auto_stall", cpu_stall, 1);
        chk("auto_count", cycle_count, 45);
        chk("auto_valid", dump_valid, 1);
        chk("auto_first_index", dump_index, 0);
        wait_done_a(200, 1'b0);
        chk("auto_final_count", cycle_count, 45);
        halt_i = 1'b1;
        repeat (3) tick();
        chk("done_ignores_halt", done, 1);
        chk("done_ignores_halt_valid", dump_valid, 0);
        halt_i = 1'b0;

        // Random backpressure
        restart_a(16'd45);
        push_dump(1'b0, 9);
        wait_done_a(2000, 1'b1);

        // External halt at edge 10; halt held high during the dump is ignored
        restart_a(16'd45);
        push_dump(1'b0, 9);
        repeat (9) tick();
        chk("halt_pre_stall", cpu_stall, 0);
        halt_i = 1'b1;
        tick();
        chk("halt_stall", cpu_stall, 1);
        chk("halt_count", cycle_count, 10);
        wait_done_a(200, 1'b0);
        chk("halt_final_count", cycle_count, 10);
        halt_i = 1'b0;

        // Auto-trigger disabled, then budget raised mid-run
        restart_a(16'd0);
        repeat (1000) tick();
        chk("noauto_stall", cpu_stall, 0);
        chk("noauto_valid", dump_valid, 0);
        chk("noauto_count", cycle_count, 1000);
        push_dump(1'b0, 9);
        run_cycles = 16'd1005;
        repeat (4) tick();
        chk("late_rc_pre_stall", cpu_stall, 0);
        tick();
        chk("late_rc_stall", cpu_stall, 1);
        chk("late_rc_count", cycle_count, 1005);
        wait_done_a(200, 1'b0);

        // Reset during beat 20 abandons the dump
        restart_a(16'd45);
        push_dump(1'b0, 9);
        for (int i = 0; i < 200 && !(dump_valid && dump_index == 16'd20); i++) tick();
        chk("midrst_reached_20", dump_index, 20);
        reset_b = 1'b0;
        #1;
        chk("midrst_stall", cpu_stall, 0);
        chk("midrst_valid", dump_valid, 0);
        chk("midrst_count", cycle_count, 0);
        chk("midrst_index", dump_index, 0);
        chk("midrst_last", dump_last, 0);
        chk("midrst_done", done, 0);
        chk("midrst_beats_before", beats_a, 20);
        restart_a(16'd45);
        push_dump(1'b0, 9);
        repeat (44) tick();
        chk("midrst_pre_stall", cpu_stall, 0);
        tick();
        chk("midrst_retrig", cpu_stall, 1);
        chk("midrst_retrig_index", dump_index, 0);
        wait_done_a(200, 1'b0);

        // No data-memory window: RF beats only
        push_dump(1'b1, 0);
        reset_b_b = 1'b1;
        for (int i = 0; i < 300 && !done_b; i++) tick();
        chk("nomem_done", done_b, 1);
        chk("nomem_beats", beats_b, 32);
        chk("nomem_drained", qb.size(), 0);
        chk("nomem_count", cycle_count_b, 45);
        chk("nomem_stall", cpu_stall_b, 1);
        chk("nomem_valid", dump_valid_b, 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
